// File: rtl/sram_like_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_if
// Purpose  : One SRAM-like request/response channel. The master issues a
//            request (req/wr/size/addr/wdata) and holds it until addr_ok;
//            the slave later returns data_ok with rdata.
// Ports    : none (signal bundle only)
//            modport master : drives request fields, receives addr_ok/data_ok/rdata
//            modport slave  : receives request fields, drives addr_ok/data_ok/rdata
// Revision : 1.0 - initial release
// ============================================================================
interface sram_like_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : Shares one SRAM-like memory port between the instruction-fetch
//            master and the data-access master. One transaction in flight at
//            a time; data has priority, but fetch is forced ahead after
//            STARVE_MAX consecutive data grants made while fetch was waiting.
// Ports    : clk        - clock, all state on rising edge
//            reset      - synchronous active-high reset
//            inst       - fetch master channel (slave side of the interface)
//            data       - data master channel (slave side of the interface)
//            mem        - memory channel (master side of the interface)
//            inst_block - fetch transaction pending (req seen, data_ok not yet)
//            data_block - data transaction pending
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  wire logic        clk,
   input  wire logic        reset,
   sram_like_if.slave       inst,
   sram_like_if.slave       data,
   sram_like_if.master      mem,
   output logic             inst_block,
   output logic             data_block
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   localparam logic [CW-1:0] c_starve_max = CW'(STARVE_MAX);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_addr = 2'd1;
   localparam logic [1:0] c_st_data = 2'd2;

   logic [1:0]    r_state;
   logic          r_owner;        // 0 = inst, 1 = data
   logic [CW-1:0] r_starve_cnt;

   logic w_any_req;
   logic w_grant_inst;
   logic w_in_addr;
   logic w_in_data;
   logic w_busy;

   assign w_any_req = inst.req | data.req;
   // Fetch wins only when it is alone, or when it has waited out the limit.
   assign w_grant_inst = inst.req & (~data.req | (r_starve_cnt == c_starve_max));

   assign w_in_addr = (r_state == c_st_addr);
   assign w_in_data = (r_state == c_st_data);
   assign w_busy    = (r_state != c_st_idle);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= c_st_idle;
         r_owner      <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_any_req) begin
                  r_owner <= ~w_grant_inst;
                  r_state <= c_st_addr;
                  if (w_grant_inst) begin
                     r_starve_cnt <= '0;
                  end else if (inst.req && (r_starve_cnt != c_starve_max)) begin
                     // Fetch lost while waiting: count it toward the limit.
                     r_starve_cnt <= r_starve_cnt + 1'b1;
                  end
               end
            end
            c_st_addr: begin
               if (mem.addr_ok) begin
                  r_state <= c_st_data;
               end
            end
            c_st_data: begin
               if (mem.data_ok) begin
                  r_state <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // Request fields follow the owner; only meaningful while mem.req is high.
   assign mem.req   = w_in_addr;
   assign mem.wr    = r_owner ? data.wr    : inst.wr;
   assign mem.size  = r_owner ? data.size  : inst.size;
   assign mem.addr  = r_owner ? data.addr  : inst.addr;
   assign mem.wdata = r_owner ? data.wdata : inst.wdata;

   // Responses are steered to the owner only; anything arriving outside the
   // matching phase (e.g. a late data_ok after reset) is dropped here.
   assign inst.addr_ok = w_in_addr & ~r_owner & mem.addr_ok;
   assign data.addr_ok = w_in_addr &  r_owner & mem.addr_ok;
   assign inst.data_ok = w_in_data & ~r_owner & mem.data_ok;
   assign data.data_ok = w_in_data &  r_owner & mem.data_ok;
   assign inst.rdata   = (w_in_data & ~r_owner) ? mem.rdata : 32'h0;
   assign data.rdata   = (w_in_data &  r_owner) ? mem.rdata : 32'h0;

   // Pending from the request until the data_ok cycle, even if the master
   // has already dropped req after its addr_ok.
   assign inst_block = (inst.req | (w_busy & ~r_owner)) & ~inst.data_ok;
   assign data_block = (data.req | (w_busy &  r_owner)) & ~data.data_ok;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Purpose  : Directed self-checking bench for sram_like_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

   logic clk;
   logic reset;
   logic inst_block;
   logic data_block;

   int n_tests;
   int n_fail;

   sram_like_if inst_if ();
   sram_like_if data_if ();
   sram_like_if mem_if ();

   sram_like_arbiter #(.STARVE_MAX(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .inst       (inst_if),
      .data       (data_if),
      .mem        (mem_if),
      .inst_block (inst_block),
      .data_block (data_block)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
      inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
      data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2;
      data_if.addr = 32'h0; data_if.wdata = 32'h0;
      mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
      step(); step();
      n_tests++;
      if ({mem_if.req, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_oks: got %b want 00000",
                  {mem_if.req, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok});
      end
      n_tests++;
      if ({inst_if.rdata, data_if.rdata} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", inst_if.rdata, data_if.rdata);
      end
      n_tests++;
      if ({inst_block, data_block} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_block_idle: got %b want 00", {inst_block, data_block});
      end
      // Block is combinational from req, even while reset is held.
      inst_if.req = 1'b1;
      #1;
      n_tests++;
      if (inst_block !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_block_req: got %b want 1", inst_block);
      end
      inst_if.req = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_fetch();
      mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = 32'hdeadbeef;
      inst_if.req = 1'b1; inst_if.addr = 32'hbfc00000;
      #1;
      n_tests++;
      if ({mem_if.req, inst_block} !== 2'b01) begin
         n_fail++;
         $display("FAIL fetch_c0: req/block got %b want 01", {mem_if.req, inst_block});
      end
      step(); // cycle 1: ADDR
      n_tests++;
      if (mem_if.req !== 1'b1 || mem_if.addr !== 32'hbfc00000) begin
         n_fail++;
         $display("FAIL fetch_c1_mem: req=%b addr=%h want 1 bfc00000", mem_if.req, mem_if.addr);
      end
      n_tests++;
      if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_c1_addr_ok: got %b want 10", {inst_if.addr_ok, data_if.addr_ok});
      end
      inst_if.req = 1'b0;
      step(); // cycle 2: DATA
      n_tests++;
      if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'hdeadbeef) begin
         n_fail++;
         $display("FAIL fetch_c2_data: ok=%b rdata=%h want 1 deadbeef", inst_if.data_ok, inst_if.rdata);
      end
      n_tests++;
      if ({data_if.data_ok, data_if.rdata, mem_if.req} !== 34'h0) begin
         n_fail++;
         $display("FAIL fetch_c2_other: data_ok=%b data_rdata=%h mem_req=%b want 0 0 0",
                  data_if.data_ok, data_if.rdata, mem_if.req);
      end
      step(); // cycle 3: IDLE, held data_ok is stray and dropped
      n_tests++;
      if ({inst_if.data_ok, inst_block, mem_if.req} !== 3'b000) begin
         n_fail++;
         $display("FAIL fetch_c3_idle: ok/block/req got %b want 000",
                  {inst_if.data_ok, inst_block, mem_if.req});
      end
   endtask

   task automatic test_simultaneous();
      inst_if.req = 1'b1; inst_if.addr = 32'hbfc00004;
      data_if.req = 1'b1; data_if.wr = 1'b1; data_if.addr = 32'h80001000;
      data_if.wdata = 32'h12345678;
      step(); // ADDR, data owns
      n_tests++;
      if (mem_if.wr !== 1'b1 || mem_if.wdata !== 32'h12345678 || mem_if.addr !== 32'h80001000) begin
         n_fail++;
         $display("FAIL simul_data_first: wr=%b wdata=%h addr=%h want 1 12345678 80001000",
                  mem_if.wr, mem_if.wdata, mem_if.addr);
      end
      n_tests++;
      if ({data_if.addr_ok, inst_if.addr_ok, inst_block} !== 3'b101) begin
         n_fail++;
         $display("FAIL simul_addr_ok: d/i/iblk got %b want 101",
                  {data_if.addr_ok, inst_if.addr_ok, inst_block});
      end
      data_if.req = 1'b0; data_if.wr = 1'b0;
      step(); // DATA
      n_tests++;
      if ({data_if.data_ok, inst_if.data_ok} !== 2'b10) begin
         n_fail++;
         $display("FAIL simul_data_ok: d/i got %b want 10", {data_if.data_ok, inst_if.data_ok});
      end
      step(); // IDLE, fetch re-arbitrates
      step(); // ADDR, fetch owns
      n_tests++;
      if (mem_if.req !== 1'b1 || mem_if.addr !== 32'hbfc00004 || inst_if.addr_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_fetch_next: req=%b addr=%h ok=%b want 1 bfc00004 1",
                  mem_if.req, mem_if.addr, inst_if.addr_ok);
      end
      inst_if.req = 1'b0;
      step(); step();
   endtask

   task automatic test_starvation();
      int  n_grants;
      logic [9:0] grants; // 1 = data grant
      n_grants = 0;
      grants   = '0;
      inst_if.req = 1'b1; inst_if.addr = 32'hbfc00100;
      data_if.req = 1'b1; data_if.addr = 32'h80003000;
      for (int i = 0; i < 40 && n_grants < 10; i++) begin
         step();
         if (mem_if.req && mem_if.addr_ok) begin
            grants[n_grants] = (mem_if.addr == 32'h80003000);
            n_grants++;
         end
      end
      inst_if.req = 1'b0; data_if.req = 1'b0;
      n_tests++;
      if (n_grants != 10) begin
         n_fail++;
         $display("FAIL starve_count: got %0d grants want 10", n_grants);
      end
      for (int g = 0; g < 10; g++) begin
         n_tests++;
         if (grants[g] !== ((g % 5) != 4)) begin
            n_fail++;
            $display("FAIL starve_grant%0d: data=%b want %b", g, grants[g], ((g % 5) != 4));
         end
      end
      step(); step();
   endtask

   task automatic test_wait_states();
      int  n_aok;
      int  n_dok;
      int  n_bad;
      n_aok = 0; n_dok = 0; n_bad = 0;
      mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'hcafef00d;
      data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h80002000;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         step();
         mem_if.addr_ok = (cyc == 4);
         mem_if.data_ok = (cyc == 10);
         if (cyc == 5) data_if.req = 1'b0;
         #1;
         if (data_if.addr_ok) n_aok++;
         if (data_if.data_ok) begin
            n_dok++;
            if (data_if.rdata !== 32'hcafef00d) n_bad++;
         end
         if (inst_if.addr_ok || inst_if.data_ok) n_bad++;
         if (data_block !== (cyc < 10)) n_bad++;
         if (cyc <= 4 && (mem_if.req !== 1'b1 || mem_if.addr !== 32'h80002000 || mem_if.wr !== 1'b0))
            n_bad++;
         if (cyc > 4 && mem_if.req !== 1'b0) n_bad++;
      end
      n_tests++;
      if (n_aok != 1 || n_dok != 1) begin
         n_fail++;
         $display("FAIL wait_pulses: addr_ok=%0d data_ok=%0d want 1 1", n_aok, n_dok);
      end
      n_tests++;
      if (n_bad != 0) begin
         n_fail++;
         $display("FAIL wait_cycles: %0d bad cycles want 0", n_bad);
      end
      mem_if.data_ok = 1'b0;
   endtask

   task automatic test_reset_in_data();
      mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h55aa55aa;
      data_if.req = 1'b1; data_if.addr = 32'h80004000;
      step(); // ADDR
      data_if.req = 1'b0;
      step(); // DATA, waiting
      reset = 1'b1;
      step(); // IDLE by reset
      reset = 1'b0;
      mem_if.data_ok = 1'b1;
      #1;
      n_tests++;
      if ({inst_if.data_ok, data_if.data_ok, mem_if.req, data_block, inst_block} !== 5'b0) begin
         n_fail++;
         $display("FAIL rst_data_drop: iok/dok/req/dblk/iblk got %b want 00000",
                  {inst_if.data_ok, data_if.data_ok, mem_if.req, data_block, inst_block});
      end
      n_tests++;
      if ({inst_if.rdata, data_if.rdata} !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_rdata: got %h/%h want 0/0", inst_if.rdata, data_if.rdata);
      end
      step();
      mem_if.data_ok = 1'b0;
   endtask

   task automatic test_stray_data_ok();
      mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11112222;
      step(); step();
      n_tests++;
      if ({inst_if.data_ok, data_if.data_ok, mem_if.req} !== 3'b000) begin
         n_fail++;
         $display("FAIL stray_idle: iok/dok/req got %b want 000",
                  {inst_if.data_ok, data_if.data_ok, mem_if.req});
      end
      // A one-cycle grant latency proves the arbiter is still in IDLE.
      mem_if.data_ok = 1'b0;
      inst_if.req = 1'b1; inst_if.addr = 32'hbfc00200;
      step();
      n_tests++;
      if (mem_if.req !== 1'b1 || mem_if.addr !== 32'hbfc00200) begin
         n_fail++;
         $display("FAIL stray_then_grant: req=%b addr=%h want 1 bfc00200", mem_if.req, mem_if.addr);
      end
      inst_if.req = 1'b0;
      mem_if.data_ok = 1'b1;
      step(); step();
      mem_if.data_ok = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_wait_states();
      test_reset_in_data();
      test_stray_data_ok();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master, one-slave arbiter that shares the single SRAM-like memory port between the instruction-fetch port (fed by next-PC generation) and the data-access port (fed by the memory stage). It grants one transaction at a time, forwards the granted master's request fields to the slave and routes `addr_ok`/`data_ok`/`rdata` back to the owner only. It drives the `inst_block`/`data_block` stall signals consumed by next-PC generation. Data has priority, with a starvation limit that guarantees forward progress for fetch.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while fetch is waiting before fetch is forced ahead.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_req` / `inst_wr` in 1 / 1: fetch request / write flag (fetch always 0, passed through).
- `inst_size` in 2: access size.
- `inst_addr` / `inst_wdata` in 32 / 32.
- `inst_addr_ok` / `inst_data_ok` out 1 / 1.
- `inst_rdata` out 32.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`: in, widths 1/1/2/32/32, data-port request fields.
- `data_addr_ok` / `data_data_ok` out 1 / 1.
- `data_rdata` out 32.
- `mem_req`, `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata`: out, widths 1/1/2/32/32, slave request fields.
- `mem_addr_ok` / `mem_data_ok` in 1 / 1.
- `mem_rdata` in 32.
- `inst_block` out 1: fetch transaction pending (requested, `data_ok` not yet returned).
- `data_block` out 1: same for the data port.

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `state`, `owner` (0 = inst, 1 = data), `starve_cnt` (width clog2(STARVE_MAX+1), saturating).
- IDLE:
  - No request: stay in IDLE.
  - Any request present: latch `owner` and go to ADDR.
  - Grant rule: data wins, unless `inst_req && starve_cnt == STARVE_MAX`, in which case inst wins.
- ADDR:
  - `mem_req` = 1; `mem_wr`, `mem_size`, `mem_addr`, `mem_wdata` are the owner's inputs, passed combinationally. Masters must hold their fields stable until their `addr_ok`.
  - `<owner>_addr_ok` = `mem_addr_ok`. The non-owner's `addr_ok` is 0.
  - On `mem_addr_ok`: go to DATA.
- DATA:
  - `mem_req` = 0.
  - `<owner>_data_ok` = `mem_data_ok`, and `<owner>_rdata` = `mem_rdata`.
  - On `mem_data_ok`: go to IDLE.
- In all other states, `*_addr_ok` and `*_data_ok` are 0 and `*_rdata` is 0. A `mem_data_ok` arriving in IDLE or ADDR is dropped.
- `starve_cnt` update at each grant (IDLE→ADDR):
  - Data granted while `inst_req` = 1: increment, saturating at STARVE_MAX.
  - Inst granted: clear to 0.
  - Data granted with no inst request: unchanged.
- Blocks:
  - `inst_block` = `inst_req` || (state ≠ IDLE && owner = 0), AND NOT `inst_data_ok`.
  - `data_block` is the same expression with owner = 1 and `data_data_ok`.
- Only one outstanding transaction exists, so no reordering is possible.

## Timing
- Reset values: `state` = IDLE, `owner` = 0, `starve_cnt` = 0. All `*_ok` outputs = 0, `mem_req` = 0, all rdata = 0.
- `*_block` outputs are combinational from `*_req` and may be 1 in the reset cycle if a request is asserted.
- Reset mid-transaction: next cycle is IDLE. `mem_req` drops and any late `mem_data_ok` is discarded.
- Latency for a granted request with zero-wait slave:
  - Request seen in cycle 0; ADDR in cycle 1, with `addr_ok` in cycle 1 if `mem_addr_ok` = 1.
  - DATA in cycle 2; `data_ok` in cycle 2 if `mem_data_ok` = 1.
  - IDLE in cycle 3.
  - Back-to-back throughput is therefore one transaction per 3 cycles minimum.
- `addr_ok` and `data_ok` to masters have zero added latency relative to the slave (combinational) in ADDR/DATA.
- A master dropping `req` before its `addr_ok`: the transaction still completes on the slave, and `data_ok` is still returned to that owner.
- Both masters requesting in IDLE: exactly one grant. The loser waits in IDLE re-arbitration after the current transaction completes.

## Test plan
- Single fetch, zero-wait slave: `inst_req` = 1, `inst_addr` = 0xbfc00000 at cycle 0.
  - Required: `mem_req` = 1 and `mem_addr` = 0xbfc00000 at cycle 1.
  - `inst_addr_ok` at cycle 1; `inst_data_ok` with `inst_rdata` = `mem_rdata` at cycle 2.
  - `data_*_ok` stay 0 throughout.
- Simultaneous requests: `inst_req` and `data_req` (wr = 1, addr 0x80001000, wdata 0x12345678) both at cycle 0.
  - Required: data is granted first (`mem_wr` = 1, `mem_wdata` = 0x12345678).
  - Fetch grant follows in the next IDLE.
- Starvation, STARVE_MAX = 4: `data_req` held continuously and `inst_req` held continuously.
  - Required: exactly 4 data transactions, then 1 inst transaction, then `starve_cnt` = 0 and the cycle repeats.
- Slave wait states: `mem_addr_ok` delayed 3 cycles, `mem_data_ok` delayed 5 cycles.
  - Required: `mem_req` and fields are held stable through ADDR, and the owner sees exactly one `addr_ok` pulse and one `data_ok` pulse.
  - `data_block` stays 1 until the `data_ok` cycle.
- Reset in DATA: assert `reset` one cycle while waiting `data_ok`, then pulse `mem_data_ok`.
  - Required: state is IDLE and the pulse is not forwarded to either master.
  - All outputs return to reset values.
- Stray `mem_data_ok` in IDLE with no requests: no `*_data_ok` output and no state change.
